// File: rtl/wave_packetizer.sv
// wave_packetizer: walks the sample-select stage through indices
// 1..NUM_SAMPLES+1 and streams the returned words, the last being the
// wave number, as one framed 16-bit packet over a valid/ready handshake.
// One word is in flight at a time, so with tx_ready held high each word
// costs three clocks (FETCH, CAPT, SEND).
// A wave_ready that arrives while a frame is running is held as pending.
// Any further wave_ready while one is already pending is counted in a
// saturating drop counter.
// Optional build macro: HDR_PREFIX_EN. When it is defined, each packet
// starts with HEADER_WORD, which carries sop.
module wave_packetizer #(
   parameter int unsigned NUM_SAMPLES = 1000,
   parameter logic [15:0] HEADER_WORD = 16'hADC0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wave_ready,
   input  logic [15:0] waveSample,
   output logic [15:0] sampleNum,
   output logic        acquire,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   output logic        tx_sop,
   output logic        tx_eop,
   input  logic        tx_ready,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] drop_count
);

   // The wave-number word index must fit the 16-bit word counter.
   generate
      if ((NUM_SAMPLES + 1 > 65535) || ($bits(HEADER_WORD) != 16)) begin : g_bad_cfg
         $error("wave_packetizer: NUM_SAMPLES+1 must be <= 65535");
      end
   endgenerate

   localparam logic [15:0] LAST_K = 16'(NUM_SAMPLES + 1);

`ifdef HDR_PREFIX_EN
   localparam logic HDR_EN = 1'b1;
`else
   localparam logic HDR_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef HDR_PREFIX_EN
      S_HDR,
`endif
      S_FETCH,
      S_CAPT,
      S_SEND
   } state_t;

   state_t      state;
   logic [15:0] k;
   logic        pending;

   // Frame sequencer: every output is registered and is set on the
   // transition into the state that owns it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         k          <= '0;
         pending    <= 1'b0;
         sampleNum  <= '0;
         acquire    <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         tx_sop     <= 1'b0;
         tx_eop     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         drop_count <= '0;
      end else begin
         frame_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (wave_ready || pending) begin
                  // A fresh pulse that coincides with a pending start stays pending.
                  pending <= pending & wave_ready;
                  k       <= 16'd1;
                  busy    <= 1'b1;
`ifdef HDR_PREFIX_EN
                  state    <= S_HDR;
                  tx_data  <= HEADER_WORD;
                  tx_valid <= 1'b1;
                  tx_sop   <= 1'b1;
                  tx_eop   <= 1'b0;
`else
                  state     <= S_FETCH;
                  sampleNum <= 16'd1;
                  acquire   <= 1'b1;
`endif
               end
            end
`ifdef HDR_PREFIX_EN
            S_HDR: begin
               if (tx_ready) begin
                  tx_valid  <= 1'b0;
                  tx_sop    <= 1'b0;
                  sampleNum <= k;
                  acquire   <= 1'b1;
                  state     <= S_FETCH;
               end
            end
`endif
            S_FETCH: begin
               acquire <= 1'b0;
               state   <= S_CAPT;
            end
            S_CAPT: begin
               tx_data  <= waveSample;
               tx_valid <= 1'b1;
               tx_sop   <= (k == 16'd1) && !HDR_EN;
               tx_eop   <= (k == LAST_K);
               state    <= S_SEND;
            end
            S_SEND: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  tx_sop   <= 1'b0;
                  tx_eop   <= 1'b0;
                  if (k == LAST_K) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     sampleNum  <= '0;
                     state      <= S_IDLE;
                  end else begin
                     k         <= k + 16'd1;
                     sampleNum <= k + 16'd1;
                     acquire   <= 1'b1;
                     state     <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase

         // Overrun tracking while a frame is in progress. This includes the
         // cycle in which the eop word is accepted.
         if (state != S_IDLE && wave_ready) begin
            if (!pending)
               pending <= 1'b1;
            else if (drop_count != 16'hFFFF)
               drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_wave_packetizer.sv
// Directed bench for wave_packetizer.
// A behavioural select stage returns i-1 for sampleNum i in 1..1000, and
// returns wave number 7 for index 1001.
module tb_wave_packetizer;

   localparam int NS = 1000;
`ifdef HDR_PREFIX_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int WORDS     = NS + 1 + HDR;
   localparam int FRAME_CLK = 3 * (NS + 1) + HDR;

   logic        clk = 1'b0;
   logic        rst;
   logic        wave_ready;
   logic [15:0] waveSample = '0;
   logic [15:0] sampleNum;
   logic        acquire;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_sop;
   logic        tx_eop;
   logic        tx_ready;
   logic        busy;
   logic        frame_done;
   logic [15:0] drop_count;

   int total = 0;
   int bad   = 0;

   wave_packetizer #(.NUM_SAMPLES(NS), .HEADER_WORD(16'hADC0)) dut (
      .clk(clk), .rst(rst), .wave_ready(wave_ready), .waveSample(waveSample),
      .sampleNum(sampleNum), .acquire(acquire), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // Select stage model: the registered sample is valid one clk after acquire.
   always @(posedge clk)
      if (acquire)
         waveSample <= (sampleNum == 16'(NS + 1)) ? 16'd7 : sampleNum - 16'd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_sampleNum"}, sampleNum, 0);
      chk({pfx, "_acquire"}, acquire, 0);
      chk({pfx, "_tx_data"}, tx_data, 0);
      chk({pfx, "_tx_valid"}, tx_valid, 0);
      chk({pfx, "_tx_sop"}, tx_sop, 0);
      chk({pfx, "_tx_eop"}, tx_eop, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_frame_done"}, frame_done, 0);
      chk({pfx, "_drop_count"}, drop_count, 0);
   endtask

   // Pulse wave_ready across one posedge.
   // Returns at the negedge just after the frame-start edge.
   task automatic start_frame();
      wave_ready = 1'b1;
      @(negedge clk);
      wave_ready = 1'b0;
   endtask

   // Follows one frame from the negedge after its start edge.
   //   pct    : tx_ready duty in percent (100 = always ready).
   //   pulses : extra wave_ready pulses at cycles 100, 200 and 300.
   //   abort_w: return once this many words have been accepted (-1 = never).
   task automatic run_frame(input int pct, input int pulses, input int abort_w, output int words);
      int idx = 0, acq = 0, cyc = 0, s;
      logic [15:0] pd = '0, ed;
      logic pv = 1'b0, pr = 1'b0, psop = 1'b0, peop = 1'b0;
      bit done = 1'b0;
      while (!done) begin
         if (acquire) begin
            acq++;
            chk("sampleNum_on_acquire", sampleNum, idx - HDR + 1);
         end
         if (pv && !pr) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, pd);
            chk("hold_sop", tx_sop, psop);
            chk("hold_eop", tx_eop, peop);
         end
         if (frame_done) begin
            chk("word_count", idx, WORDS);
            chk("acquire_count", acq, NS + 1);
            chk("busy_after_done", busy, 0);
            if (pct >= 100) chk("frame_clk", cyc, FRAME_CLK);
            done = 1'b1;
         end else if (abort_w >= 0 && idx == abort_w) begin
            done = 1'b1;
         end else if (cyc >= 20000) begin
            chk("frame_timeout", frame_done, 1);
            done = 1'b1;
         end else begin
            wave_ready = (pulses > 0 && cyc > 0 && cyc % 100 == 0 && cyc / 100 <= pulses);
            tx_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            pv = tx_valid; pr = tx_ready; pd = tx_data; psop = tx_sop; peop = tx_eop;
            if (tx_valid && tx_ready) begin
               s = idx - HDR;
               if (HDR == 1 && idx == 0) ed = 16'hADC0;
               else if (s < NS)          ed = 16'(s);
               else                      ed = 16'd7;
               chk("word_data", tx_data, ed);
               chk("word_sop", tx_sop, idx == 0);
               chk("word_eop", tx_eop, idx == WORDS - 1);
               idx++;
            end
            @(negedge clk);
            cyc++;
         end
      end
      wave_ready = 1'b0;
      words = idx;
   endtask

   initial begin
      int w;
      rst = 1'b1; wave_ready = 1'b0; tx_ready = 1'b0;
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame, tx_ready held high.
      start_frame();
      run_frame(100, 0, -1, w);
      repeat (3) @(negedge clk);

      // Backpressure, 30% ready duty.
      start_frame();
      run_frame(30, 0, -1, w);
      repeat (3) @(negedge clk);

      // Overrun: three pulses during frame 1 give one pending frame and two drops.
      start_frame();
      run_frame(100, 3, -1, w);
      chk("overrun_drops", drop_count, 2);
      @(negedge clk);
      chk("pending_start_busy", busy, 1);
      run_frame(100, 0, -1, w);
      repeat (20) @(negedge clk);
      chk("no_third_frame_busy", busy, 0);
      chk("no_third_frame_acq", acquire, 0);
      chk("overrun_drops_after", drop_count, 2);

      // Saturation: stall the frame and hold wave_ready high.
      tx_ready = 1'b0;
      wave_ready = 1'b1;
      repeat (65540) @(negedge clk);
      wave_ready = 1'b0;
      chk("drop_saturated", drop_count, 16'hFFFF);
      repeat (3) begin
         wave_ready = 1'b1;
         @(negedge clk);
         wave_ready = 1'b0;
         @(negedge clk);
      end
      chk("drop_stays_saturated", drop_count, 16'hFFFF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("drop_cleared_by_rst", drop_count, 0);
      @(negedge clk);

      // Mid-frame reset at word 500; outputs clear without a clock edge.
      start_frame();
      run_frame(100, 0, 500, w);
      chk("abort_word", w, 500);
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_frame();
      run_frame(100, 0, -1, w);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wave_packetizer.md
Name: wave_packetizer

Overview:
- Downstream neighbour of the waveform sample-select stage.
- On each captured waveform, it walks sampleNum through 1..NUM_SAMPLES+1 and drives acquire.
- It collects the registered waveSample words, including the trailing wave number, and streams them as one framed 16-bit packet to the Ethernet TX path over a valid/ready handshake.
- It also tracks frames that are dropped while busy.

Parameters:
- NUM_SAMPLES, 1000, waveform samples per frame; the wave-number word is index NUM_SAMPLES+1.
- HEADER_WORD, 16'hADC0, magic word emitted when HDR_PREFIX_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wave_ready  in  1  single-cycle pulse: a new waveform is stable in the capture buffer.
- waveSample  in  16  registered sample from the select stage; valid 1 clk after sampleNum/acquire are presented.
- sampleNum  out  16  index driven to the select stage.
- acquire  out  1  read enable to the select stage.
- tx_data  out  16  packet word.
- tx_valid  out  1  tx_data valid.
- tx_sop  out  1  first word of packet, qualified by tx_valid.
- tx_eop  out  1  last word of packet, qualified by tx_valid.
- tx_ready  in  1  downstream accepts the word when tx_valid && tx_ready.
- busy  out  1  frame in progress.
- frame_done  out  1  1-clk pulse on acceptance of the eop word.
- drop_count  out  16  saturating count of discarded wave_ready pulses.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE, word index k=0, pending=0.
- States: IDLE, HDR (only with HDR_PREFIX_EN), FETCH, CAPT, SEND.
- IDLE:
  - sampleNum=0, acquire=0, busy=0.
  - On wave_ready, or pending=1: clear pending, set k=1, go to FETCH (or HDR when enabled).
- FETCH:
  - sampleNum=k, acquire=1 for exactly this cycle.
  - Next state: CAPT.
- CAPT:
  - acquire=0, sampleNum holds k.
  - waveSample now holds word k; register it into tx_data.
  - Set tx_valid=1, tx_sop=(k==1 && no header), tx_eop=(k==NUM_SAMPLES+1).
  - Next state: SEND.
- SEND:
  - Hold tx_data, tx_valid, tx_sop and tx_eop stable until tx_ready.
  - On accept, if k==NUM_SAMPLES+1: tx_valid=0, pulse frame_done, go to IDLE.
  - Otherwise: k=k+1, tx_valid=0, go to FETCH.
- Throughput is 3 clk per word with tx_ready held high; a frame is 3*(NUM_SAMPLES+1) clk, i.e. 3003 clk at default.
- acquire is never high outside FETCH, so the select stage holds its output while the block waits.
- Order guarantee: word k+1 is never fetched before word k is accepted.
- wave_ready while busy:
  - If pending=0: set pending=1; serviced immediately after the current frame, with no IDLE dwell beyond 1 clk.
  - If pending=1 already: drop_count++, saturating at 16'hFFFF.
- wave_ready in the same cycle as a frame_done accept: treated as pending; the next frame starts normally.
- drop_count clears only on rst.
- Reset mid-frame: immediate return to reset values; no eop is emitted, and the downstream discards the partial packet on its sop/timeout rules.
- Width rules:
  - k is 16 bits.
  - NUM_SAMPLES+1 must be ≤ 65535; elaboration fails otherwise.

Optional Feature:
- Macro: HDR_PREFIX_EN.
- Defined:
  - Frame start enters HDR: tx_data=HEADER_WORD, tx_valid=1, tx_sop=1, with no acquire.
  - On accept, go to FETCH with k=1; the sample words then carry tx_sop=0.
  - Packet is NUM_SAMPLES+2 words.
- Undefined:
  - HDR state is absent; the first sample word carries tx_sop.
  - Packet is NUM_SAMPLES+1 words.

Test Plan:
- Basic frame (model select stage with waveform[i]=i, wavenum=7; tx_ready=1; pulse wave_ready):
  - 1001 words 0..999 then 7.
  - sop on word 1, eop on word 1001.
  - frame_done 3003 clk after start.
  - acquire high exactly 1001 cycles.
- Backpressure (tx_ready random 30% duty):
  - Identical word sequence, with tx_data stable while tx_valid && !tx_ready.
  - sampleNum never advances ahead of the accepted word.
- Overrun (3 wave_ready pulses during frame 1):
  - Exactly one extra frame follows; drop_count=2.
- Saturation (force drop_count near max, 3 further overruns):
  - drop_count stays at 16'hFFFF.
- Mid-frame reset (assert rst at word 500):
  - All outputs are 0 asynchronously.
  - A subsequent wave_ready produces a full, correct frame starting at sampleNum=1.
- HDR_PREFIX_EN build:
  - First word is 16'hADC0 with sop.
  - 1002 words total; eop on the wave-number word.
